// File: rtl/lisnoc_vc_link_buffer.sv
// Virtual-channel link buffer: one circular FIFO per VC, round-robin output grant.
// Defining LISNOC_LINK_BUFFER_STATS_EN adds per-VC saturating popped-flit counters.
module lisnoc_vc_link_buffer #(
    parameter int FLIT_WIDTH = 34,
    parameter int VCHANNELS  = 3,
    parameter int DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [FLIT_WIDTH-1:0]                 in_flit,
    input  logic [VCHANNELS-1:0]                  in_valid,
    output logic [VCHANNELS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]                 out_flit,
    output logic [VCHANNELS-1:0]                  out_valid,
    input  logic [VCHANNELS-1:0]                  out_ready,
`ifdef LISNOC_LINK_BUFFER_STATS_EN
    input  logic                                  stat_clear,
    output logic [VCHANNELS*16-1:0]               stat_flits,
`endif
    output logic [VCHANNELS*$clog2(DEPTH+1)-1:0]  fill_level
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [VW-1:0] LAST_VC    = VW'(VCHANNELS - 1);
    localparam logic [VW:0]   NUM_VC     = (VW + 1)'(VCHANNELS);

    logic [FLIT_WIDTH-1:0] r_mem   [VCHANNELS][DEPTH];
    logic [PW-1:0]         r_rptr  [VCHANNELS];
    logic [PW-1:0]         r_wptr  [VCHANNELS];
    logic [CW-1:0]         r_count [VCHANNELS];
    logic [VW-1:0]         r_rr;

    logic [VCHANNELS-1:0]  w_in_sel;
    logic [VCHANNELS-1:0]  w_ready;
    logic [VCHANNELS-1:0]  w_push;
    logic [VCHANNELS-1:0]  w_elig;
    logic [VCHANNELS-1:0]  w_grant;
    logic [VW-1:0]         w_grant_idx;
    logic                  w_any_grant;
    logic [VW:0]           w_scan;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Isolate the lowest set bit of in_valid; higher bits never push.
    assign w_in_sel = in_valid & (~in_valid + VCHANNELS'(1));

    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_ready = '0;
        w_push  = '0;
        w_elig  = '0;
        for (int v = 0; v < VCHANNELS; v++) begin
            w_ready[v] = (r_count[v] != FULL_COUNT) && rst_n;
            w_push[v]  = w_in_sel[v] && w_ready[v];
            w_elig[v]  = (r_count[v] != '0) && out_ready[v];
        end
    end

    assign in_ready = w_ready;

    // Round-robin scan starting at r_rr; eligibility already includes out_ready.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_any_grant = 1'b0;
        w_scan      = '0;
        for (int i = 0; i < VCHANNELS; i++) begin
            w_scan = {1'b0, r_rr} + (VW + 1)'(i);
            if (w_scan >= NUM_VC) begin
                w_scan = w_scan - NUM_VC;
            end
            if (!w_any_grant && w_elig[w_scan[VW-1:0]]) begin
                w_any_grant                 = 1'b1;
                w_grant_idx                 = w_scan[VW-1:0];
                w_grant[w_scan[VW-1:0]]     = 1'b1;
            end
        end
    end

    assign out_valid = w_grant;

    always_comb begin
        out_flit = '0;
        for (int v = 0; v < VCHANNELS; v++) begin
            if (w_grant[v]) begin
                out_flit = out_flit | r_mem[v][r_rptr[v]];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VCHANNELS; v++) begin
                r_rptr[v]  <= '0;
                r_wptr[v]  <= '0;
                r_count[v] <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int v = 0; v < VCHANNELS; v++) begin
                if (w_push[v]) begin
                    r_wptr[v] <= ptr_next(r_wptr[v]);
                end
                if (w_grant[v]) begin
                    r_rptr[v] <= ptr_next(r_rptr[v]);
                end
                case ({w_push[v], w_grant[v]})
                    2'b10:   r_count[v] <= r_count[v] + CW'(1);
                    2'b01:   r_count[v] <= r_count[v] - CW'(1);
                    default: r_count[v] <= r_count[v];
                endcase
            end
            if (w_any_grant) begin
                r_rr <= (w_grant_idx == LAST_VC) ? '0 : w_grant_idx + VW'(1);
            end
        end
    end

    // NOTE: flit storage has no reset; occupancy counts gate every read, so
    // stale entries are never presented and reset stays cheap.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VCHANNELS; v++) begin
            if (w_push[v]) begin
                r_mem[v][r_wptr[v]] <= in_flit;
            end
        end
    end

    always_comb begin
        fill_level = '0;
        for (int v = 0; v < VCHANNELS; v++) begin
            fill_level[v*CW +: CW] = r_count[v];
        end
    end

`ifdef LISNOC_LINK_BUFFER_STATS_EN
    logic [15:0] r_stat [VCHANNELS];

    // Clear outranks a same-cycle increment; counters stick at 16'hFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VCHANNELS; v++) begin
                r_stat[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VCHANNELS; v++) begin
                if (stat_clear) begin
                    r_stat[v] <= '0;
                end else if (w_grant[v] && (r_stat[v] != 16'hFFFF)) begin
                    r_stat[v] <= r_stat[v] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_flits = '0;
        for (int v = 0; v < VCHANNELS; v++) begin
            stat_flits[v*16 +: 16] = r_stat[v];
        end
    end
`endif

endmodule

// File: tb/tb_lisnoc_vc_link_buffer.sv
// Scoreboard bench for lisnoc_vc_link_buffer: per-VC expected-flit queues plus a
// queue-size-based round-robin reference, checked every falling edge.
module tb_lisnoc_vc_link_buffer;

    localparam int FW = 34;
    localparam int VC = 3;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [FW-1:0]      in_flit = '0;
    logic [VC-1:0]      in_valid = '0;
    logic [VC-1:0]      in_ready;
    logic [FW-1:0]      out_flit;
    logic [VC-1:0]      out_valid;
    logic [VC-1:0]      out_ready = '0;
    logic [VC*CW-1:0]   fill_level;
`ifdef LISNOC_LINK_BUFFER_STATS_EN
    logic               stat_clear = 1'b0;
    logic [VC*16-1:0]   stat_flits;
`endif

    always #5 clk = ~clk;

    lisnoc_vc_link_buffer #(
        .FLIT_WIDTH (FW),
        .VCHANNELS  (VC),
        .DEPTH      (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef LISNOC_LINK_BUFFER_STATS_EN
        .stat_clear (stat_clear),
        .stat_flits (stat_flits),
`endif
        .fill_level (fill_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: expected contents per VC, round-robin pointer, pop counts.
    logic [FW-1:0] sb_q [VC][$];
    int            rr_m = 0;
    int            pops_m [VC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [VC-1:0] exp_ready;
        logic [VC-1:0] exp_grant;
        logic [FW-1:0] exp_flit;
        int            g;
        int            sel;
        int            idx;
        if (!rst_n) begin
            check("rst_in_ready",  64'(in_ready),   64'd0);
            check("rst_out_valid", 64'(out_valid),  64'd0);
            check("rst_out_flit",  64'(out_flit),   64'd0);
            check("rst_fill",      64'(fill_level), 64'd0);
            for (int v = 0; v < VC; v++) begin
                sb_q[v].delete();
                pops_m[v] = 0;
            end
            rr_m = 0;
        end else begin
            for (int v = 0; v < VC; v++) begin
                exp_ready[v] = (sb_q[v].size() < D);
            end
            g = -1;
            for (int i = 0; i < VC; i++) begin
                idx = (rr_m + i) % VC;
                if (g < 0 && sb_q[idx].size() > 0 && out_ready[idx]) begin
                    g = idx;
                end
            end
            exp_grant = (g >= 0) ? (VC'(1) << g) : '0;
            exp_flit  = (g >= 0) ? sb_q[g][0] : '0;

            check("in_ready",  64'(in_ready),  64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(exp_grant));
            check("out_flit",  64'(out_flit),  64'(exp_flit));
            for (int v = 0; v < VC; v++) begin
                check("fill_level", 64'(fill_level[v*CW +: CW]), 64'(sb_q[v].size()));
`ifdef LISNOC_LINK_BUFFER_STATS_EN
                check("stat_flits", 64'(stat_flits[v*16 +: 16]), 64'(pops_m[v]));
`endif
            end

            // Commit the transfers that the coming rising edge will perform.
            if (g >= 0) begin
                void'(sb_q[g].pop_front());
                rr_m = (g + 1) % VC;
            end
`ifdef LISNOC_LINK_BUFFER_STATS_EN
            for (int v = 0; v < VC; v++) begin
                if (stat_clear) pops_m[v] = 0;
                else if (v == g && pops_m[v] < 65535) pops_m[v] = pops_m[v] + 1;
            end
`endif
            sel = -1;
            for (int v = 0; v < VC; v++) begin
                if (sel < 0 && in_valid[v]) sel = v;
            end
            if (sel >= 0 && exp_ready[sel]) begin
                sb_q[sel].push_back(in_flit);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input logic [FW-1:0] f);
        in_valid = VC'(1) << v;
        in_flit  = f;
        tick();
        in_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [VC-1:0] exp_order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [63:0]   rnd;
    int            n_vc2;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // In-order drain of a full VC1.
        for (int i = 1; i <= 4; i++) push(1, 34'h1_0000_0000 + FW'(i));
        check("vc1_full_ready", 64'(in_ready[1]), 64'd0);
        check("vc1_full_fill",  64'(fill_level[CW +: CW]), 64'd4);
        out_ready = 3'b111;
        repeat (6) tick();
        check("vc1_drained", 64'(fill_level), 64'd0);

        // Round-robin grant order across three preloaded VCs.
        out_ready = '0;
        do_reset();
        for (int v = 0; v < VC; v++) begin
            push(v, FW'(32'h100 * (v + 1) + 1));
            push(v, FW'(32'h100 * (v + 1) + 2));
        end
        out_ready = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("grant_order", 64'(out_valid), 64'(exp_order[i]));
        end
        tick();

        // A stalled VC0 does not block VC2.
        out_ready = '0;
        do_reset();
        push(0, 34'h3_0000_0001);
        push(0, 34'h3_0000_0002);
        push(2, 34'h3_0000_0003);
        push(2, 34'h3_0000_0004);
        out_ready = 3'b110;
        repeat (4) tick();
        check("stall_vc0_fill", 64'(fill_level[0 +: CW]),    64'd2);
        check("stall_vc2_fill", 64'(fill_level[2*CW +: CW]), 64'd0);

        // Full VC2 streaming with continuous in_valid: one pop per cycle.
        out_ready = '0;
        do_reset();
        for (int i = 0; i < D; i++) push(2, 34'h2_0000_0000 + FW'(i));
        out_ready = 3'b100;
        in_valid  = 3'b100;
        n_vc2     = 0;
        for (int i = 0; i < 20; i++) begin
            in_flit = 34'h2_0000_0100 + FW'(i);
            @(negedge clk);
            n_vc2 += int'(out_valid[2]);
            tick();
        end
        in_valid = '0;
        check("vc2_throughput", 64'(n_vc2), 64'd20);

        // Multi-hot in_valid: only the lowest set bit pushes.
        out_ready = '0;
        do_reset();
        in_valid = 3'b101;
        in_flit  = 34'h0_0000_0ABC;
        tick();
        in_valid = '0;
        check("multihot_vc0", 64'(fill_level[0 +: CW]),    64'd1);
        check("multihot_vc2", 64'(fill_level[2*CW +: CW]), 64'd0);

        // Asynchronous reset with flits buffered clears everything at once.
        push(1, 34'h1_0000_00AA);
        push(1, 34'h1_0000_00BB);
        out_ready = 3'b111;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid),  64'd0);
        check("async_rst_fill",  64'(fill_level), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef LISNOC_LINK_BUFFER_STATS_EN
        check("stat_after_rst", 64'(stat_flits), 64'd0);
        out_ready = 3'b010;
        for (int i = 0; i < 5; i++) push(1, 34'h1_0000_0500 + FW'(i));
        repeat (3) tick();
        check("stat_vc1_five", 64'(stat_flits[31:16]), 64'd5);
`endif

        // Randomized traffic, including multi-hot in_valid and stray resets.
        for (int i = 0; i < 3000; i++) begin
            rnd       = {$urandom(), $urandom()};
            in_flit   = rnd[FW-1:0];
            in_valid  = VC'($urandom_range(0, 7));
            out_ready = VC'($urandom_range(0, 7));
`ifdef LISNOC_LINK_BUFFER_STATS_EN
            stat_clear = ($urandom_range(0, 63) == 0);
`endif
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        in_valid  = '0;
        out_ready = 3'b111;
`ifdef LISNOC_LINK_BUFFER_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (20) tick();
        check("final_drain", 64'(fill_level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
